// File: rtl/prog_loader_if.sv
// Byte-stream channel feeding the program loader.
// The source drives valid/data/last; the loader answers with ready.
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs a byte stream little-endian into instruction
// words, writes them to instruction RAM and holds the CPU until done.
module prog_loader #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    prog_loader_if.slave      bus,
    output logic              weI,
    output logic [WORD_W-1:0] dinI,
    output logic [ADDR_W-1:0] addrI,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);
    localparam int NB = WORD_W / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, ERR} state_t;

    state_t            state;
    logic [IW-1:0]     idx;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] packed_word;
    logic              last_seen;
    logic              accept;
    logic              complete;

    // Word as it looks once the incoming byte lands in its lane.
    always_comb begin
        packed_word = word;
        packed_word[8*int'(idx) +: 8] = bus.in_data;
    end

    assign accept   = (state == LOAD) && bus.in_valid && bus.in_ready;
    assign complete = (idx == LAST_IDX) || bus.in_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            word         <= '0;
            last_seen    <= 1'b0;
            bus.in_ready <= 1'b0;
            weI          <= 1'b0;
            dinI         <= '0;
            addrI        <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            word_count   <= '0;
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LOAD;
                        idx          <= '0;
                        word         <= '0;
                        word_count   <= '0;
                        bus.in_ready <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (!complete) begin
                            idx  <= idx + 1'b1;
                            word <= packed_word;
                        end else if (word_count == FULL) begin
                            // RAM is full: abort without wrapping the address
                            state        <= ERR;
                            bus.in_ready <= 1'b0;
                            err          <= 1'b1;
                        end else begin
                            state        <= WRITE;
                            bus.in_ready <= 1'b0;
                            weI          <= 1'b1;
                            dinI         <= packed_word;
                            addrI        <= word_count[ADDR_W-1:0];
                            last_seen    <= bus.in_last;
                        end
                    end
                end
                WRITE: begin
                    weI        <= 1'b0;
                    word_count <= word_count + 1'b1;
                    idx        <= '0;
                    word       <= '0;
                    if (last_seen) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state        <= LOAD;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader (ADDR_W=2): directed table, reset sequences,
// and random loads against a word-level reference model.
module tb_prog_loader;
    typedef logic [7:0] bq_t[$];

    typedef struct {
        int           n;
        logic [159:0] b;
        int           nwr;
        logic [31:0]  lastw;
        bit           e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        weI;
    logic [31:0] dinI;
    logic [1:0]  addrI;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [2:0]  word_count;

    prog_loader_if bus();

    prog_loader #(.WORD_W(32), .ADDR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bus        (bus),
        .weI        (weI),
        .dinI       (dinI),
        .addrI      (addrI),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [33:0] wq[$];
    int m_cnt = 0;
    int m_words = 0;
    bit exp_we = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Byte-count model: the write pulse must follow the completing byte.
    always @(negedge clk) begin
        if (rst) begin
            chk("we_timing", weI, exp_we);
            if (weI) begin
                wq.push_back({addrI, dinI});
                chk("ready_in_write", bus.in_ready, 0);
            end
        end
        exp_we = 1'b0;
        if (!rst || start) begin
            m_cnt = 0;
            m_words = 0;
        end else if (bus.in_valid && bus.in_ready) begin
            if (m_cnt == 3 || bus.in_last) begin
                if (m_words < 4) begin
                    exp_we = 1'b1;
                    m_words++;
                end
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    end

    function automatic logic [31:0] exp_word(input bq_t p, input int k);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++)
            if (4 * k + j < p.size()) w[8*j +: 8] = p[4*k+j];
        return w;
    endfunction

    task automatic do_load(input bq_t p, input int gap);
        int  i;
        int  cyc;
        bit  acc;
        wq.delete();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("reload_wc", word_count, 0);
        chk("reload_hold", cpu_hold, 1);
        chk("reload_ready", bus.in_ready, 1);
        chk("reload_done", done, 0);
        @(posedge clk); #1;
        i = 0;
        cyc = 0;
        while (i < p.size() && cyc < 500) begin
            bus.in_valid = ($urandom_range(99) >= gap);
            bus.in_data  = p[i];
            bus.in_last  = (i == p.size() - 1);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (acc) i++;
            if (err) break;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        cyc = 0;
        while (!(done || err) && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("finish_timeout", (done || err), 1);
    endtask

    task automatic check_result(input bq_t p);
        int nw = (p.size() + 3) / 4;
        bit e = (nw > 4);
        int nwr = e ? 4 : nw;
        chk("num_writes", wq.size(), nwr);
        foreach (wq[k]) begin
            if (k < nwr) begin
                chk("wr_addr", wq[k][33:32], k);
                chk("wr_data", wq[k][31:0], exp_word(p, k));
            end
        end
        chk("done", done, !e);
        chk("err", err, e);
        chk("cpu_hold", cpu_hold, e);
        chk("word_count", word_count, nwr);
        chk("ready_idle", bus.in_ready, 0);
        chk("din_hold", dinI, exp_word(p, nwr - 1));
        chk("addr_hold", addrI, nwr - 1);
    endtask

    initial begin
        vec_t tbl[7];
        bq_t  p;

        tbl[0] = '{8, 160'hDEADBEEF12345678, 2, 32'hDEADBEEF, 1'b0};
        tbl[1] = '{2, 160'hBBAA, 1, 32'h0000BBAA, 1'b0};
        tbl[2] = '{4, 160'h44332211, 1, 32'h44332211, 1'b0};
        tbl[3] = '{1, 160'h5A, 1, 32'h0000005A, 1'b0};
        tbl[4] = '{16, 160'h100F0E0D0C0B0A090807060504030201, 4,
                   32'h100F0E0D, 1'b0};
        tbl[5] = '{17, 160'h11100F0E0D0C0B0A090807060504030201, 4,
                   32'h100F0E0D, 1'b1};
        tbl[6] = '{5, 160'h9988776655, 2, 32'h00000099, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;

        #1 rst = 1'b0;
        #1;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_we", weI, 0);
        chk("rst_din", dinI, 0);
        chk("rst_addr", addrI, 0);
        chk("rst_hold", cpu_hold, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wc", word_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Stream activity in IDLE must be ignored.
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b1;
        bus.in_data  = 8'hC3;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_ready", bus.in_ready, 0);
        chk("idle_wc", word_count, 0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;

        for (int v = 0; v < 7; v++) begin
            p.delete();
            for (int i = 0; i < tbl[v].n; i++) p.push_back(tbl[v].b[8*i +: 8]);
            do_load(p, (v == 0) ? 0 : 30);
            chk("tbl_nwr", wq.size(), tbl[v].nwr);
            chk("tbl_lastw", dinI, tbl[v].lastw);
            chk("tbl_err", err, tbl[v].e);
            chk("tbl_done", done, !tbl[v].e);
            chk("tbl_wc", word_count, tbl[v].nwr);
            check_result(p);
        end

        // Reset in the middle of the first word.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        @(posedge clk); #1;
        bus.in_data  = 8'h22;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ready", bus.in_ready, 0);
        chk("mid_rst_we", weI, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_hold", cpu_hold, 1);
        chk("mid_rst_wc", word_count, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", bus.in_ready, 0);
        p.delete();
        p.push_back(8'hA1);
        p.push_back(8'hB2);
        p.push_back(8'hC3);
        p.push_back(8'hD4);
        do_load(p, 0);
        chk("post_rst_word", dinI, 32'hD4C3B2A1);
        check_result(p);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(20, 1);
            p.delete();
            for (int i = 0; i < n; i++) p.push_back(8'($urandom_range(255)));
            do_load(p, $urandom_range(60));
            check_result(p);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter WORD_W, default 32, instruction word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10, instruction RAM address width in bits.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset, asynchronous and active-low (0 = reset).
REQ-005 start  input  1  single-cycle pulse that begins a program load.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  program byte.
REQ-008 in_last  input  1  marks the final byte of the program; qualified by in_valid.
REQ-009 in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both 1 on a rising edge.
REQ-010 weI  output  1  instruction RAM write enable.
REQ-011 dinI  output  WORD_W  instruction RAM write data.
REQ-012 addrI  output  ADDR_W  instruction RAM write address.
REQ-013 cpu_hold  output  1  1 = hold the CPU in reset; 0 = release.
REQ-014 done  output  1  load completed successfully.
REQ-015 err  output  1  load aborted on overflow.
REQ-016 word_count  output  ADDR_W+1  number of words written in the current or last load.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WRITE, DONE and ERR.
REQ-018 IDLE SHALL go to LOAD on start=1; all other inputs are ignored in IDLE.
REQ-019 On entry to LOAD from IDLE, DONE or ERR, the block SHALL clear the byte index, address and word_count to 0.
REQ-020 in_ready SHALL be 1 only in LOAD.
REQ-021 Bytes SHALL be packed little-endian: byte k of a word goes to bits [8k+7:8k].
REQ-022 When the block accepts the byte that completes a word, or accepts a byte with in_last=1, the FSM SHALL enter WRITE on the next edge.
REQ-023 For a partial final word, unfilled bytes SHALL be 0.
REQ-024 WRITE SHALL last exactly one cycle, with weI=1, dinI equal to the assembled word and addrI equal to the current address.
REQ-025 Latency: weI SHALL be high in the cycle immediately after the completing byte is accepted.
REQ-026 After WRITE, the address and word_count SHALL each increment by 1 and the byte index SHALL reset to 0.
REQ-027 After WRITE, the FSM SHALL return to LOAD, or go to DONE if the written word contained the in_last byte.
REQ-028 Overflow: if a word completes while word_count = 2^ADDR_W, the FSM SHALL enter ERR instead of WRITE, with no write performed and the address not wrapped.
REQ-029 An in_last byte on the exact word boundary SHALL NOT cause an extra empty word to be written.
REQ-030 weI SHALL be 0 in every state other than WRITE.
REQ-031 dinI and addrI SHALL hold their last written values outside WRITE.
REQ-032 cpu_hold SHALL be 1 in IDLE, LOAD, WRITE and ERR, and 0 only in DONE.
REQ-033 done SHALL be 1 only in DONE; err SHALL be 1 only in ERR.
REQ-034 DONE and ERR SHALL be sticky until start=1, which re-enters LOAD.
REQ-035 start SHALL be ignored in LOAD and WRITE.
REQ-036 A byte with in_valid=1 while in_ready=0 SHALL NOT be consumed.

Reset
REQ-037 While rst=0, the FSM SHALL be in IDLE and outputs SHALL be: in_ready=0, weI=0, dinI=0, addrI=0, cpu_hold=1, done=0, err=0, word_count=0; the byte index and shift register SHALL be 0.
REQ-038 Assertion of rst SHALL take effect immediately, independent of clk, including mid-load or during WRITE.
REQ-039 After a mid-load reset, the FSM SHALL remain in IDLE until the next start pulse; the partial load is discarded.

Verification
REQ-040 Basic load: start; bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE with last on 0xDE -> two writes: addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF; then done=1, cpu_hold=0, word_count=2.
REQ-041 Partial word: start; bytes 0xAA,0xBB with last on 0xBB -> one write at addr 0 of 0x0000BBAA; then done=1, word_count=1.
REQ-042 Backpressure and gaps: in_valid toggles randomly -> in_ready=0 during each WRITE cycle; no byte lost or duplicated; weI pulse exactly one cycle after the 4th accepted byte.
REQ-043 Overflow (ADDR_W=2): 17 bytes, last on byte 17 -> 4 writes to addrs 0..3, then err=1 with no fifth write, cpu_hold=1, word_count=4.
REQ-044 Reset mid-load: rst=0 after 2 bytes of word 1 -> in_ready, weI, done and err immediately 0, cpu_hold=1; new start followed by 4 bytes -> a write at addr 0.
REQ-045 Reload: start while in DONE -> word_count=0, cpu_hold=1, new program written from addr 0.
